regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: pipeline writes (A) win, multi-cycle results (B) queue in a 2-entry FIFO; B latency >=1 cycle, b_ready = FIFO not full.
// Define REGARB_BYPASS_EN to let B write in its arrival cycle when nothing valid is queued and A is idle.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_we,
  input  logic [4:0]  a_waddr,
  input  logic [31:0] a_wdata,
  input  logic        b_valid,
  input  logic [4:0]  b_waddr,
  input  logic [31:0] b_wdata,
  output logic        b_ready,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        grant_b,
  output logic        stall_req
);

  typedef enum logic [1:0] {IDLE, WAIT, STALL} state_t;

  state_t      state, state_nxt;
  logic [1:0]  vld, vld_nxt;
  logic [4:0]  ent_addr [2];
  logic [31:0] ent_data [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, count_nxt;
  logic [2:0]  starve_cnt, starve_nxt;

  logic a_wr, b_xfer, head_vld, head_grant, head_squash, byp, push, pop;

  assign a_wr        = a_we && (a_waddr != 5'd0);
  assign b_ready     = !rst && (count != 2'd2);
  assign b_xfer      = b_valid && b_ready;
  assign head_vld    = (count != 2'd0) && vld[rd_ptr];
  assign head_grant  = !rst && !a_wr && head_vld;
  assign head_squash = a_wr && head_vld && (ent_addr[rd_ptr] == a_waddr);

`ifdef REGARB_BYPASS_EN
  assign byp = b_xfer && !a_wr && (vld == 2'b00) && (b_waddr != 5'd0);
`else
  assign byp = 1'b0;
`endif

  // Writes to r0 complete the handshake but never occupy a slot.
  assign push = b_xfer && (b_waddr != 5'd0) && !byp;
  assign pop  = (count != 2'd0) && (!vld[rd_ptr] || head_grant);

  always_comb begin
    we      = 1'b0;
    waddr   = 5'd0;
    wdata   = 32'd0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a_wr) begin
        we    = 1'b1;
        waddr = a_waddr;
        wdata = a_wdata;
      end else if (head_vld) begin
        we      = 1'b1;
        waddr   = ent_addr[rd_ptr];
        wdata   = ent_data[rd_ptr];
        grant_b = 1'b1;
      end else if (byp) begin
        we      = 1'b1;
        waddr   = b_waddr;
        wdata   = b_wdata;
        grant_b = 1'b1;
      end
    end
  end

  assign stall_req = !rst && (state == STALL);

  // A is newer than anything queued, so a matching A write kills stale B data,
  // including an entry landing in the same cycle.
  always_comb begin
    vld_nxt = vld;
    if (a_wr) begin
      for (int i = 0; i < 2; i++) begin
        if (ent_addr[i] == a_waddr) vld_nxt[i] = 1'b0;
      end
    end
    if (pop)  vld_nxt[rd_ptr] = 1'b0;
    if (push) vld_nxt[wr_ptr] = !(a_wr && (b_waddr == a_waddr));

    count_nxt = count + {1'b0, push} - {1'b0, pop};

    starve_nxt = starve_cnt;
    if (head_grant || head_squash)
      starve_nxt = 3'd0;
    else if (head_vld && a_wr && (starve_cnt != 3'd4))
      starve_nxt = starve_cnt + 3'd1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STALL: begin
        if (head_grant || head_squash)
          state_nxt = (vld_nxt != 2'b00) ? WAIT : IDLE;
      end
      default: begin
        if (starve_nxt == 3'd4)
          state_nxt = STALL;
        else if (vld_nxt != 2'b00)
          state_nxt = WAIT;
        else
          state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld        <= 2'b00;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      starve_cnt <= 3'd0;
    end else begin
      vld        <= vld_nxt;
      count      <= count_nxt;
      starve_cnt <= starve_nxt;
      if (push) begin
        ent_addr[wr_ptr] <= b_waddr;
        ent_data[wr_ptr] <= b_wdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

endmodule
